// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter and its round-robin picker.
// The read-side scheduler can reuse these definitions.
package fifo_arb_pkg;

    localparam int FIFO_DW       = 140;
    localparam int DEF_N_REQ     = 4;
    localparam int DEF_MAX_BEATS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Increment modulo n; used to move the priority pointer past the last winner.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: returns the first set request at or
// after ptr, wrapping from N-1 back to 0.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        idx    = '0;
        any    = |req;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = PW'((int'(ptr) + k) % N);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-atomic round-robin arbiter sharing the async_fifo write port among
// N_REQ valid/ready requesters, with forced release of overlong packets.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DW        = FIFO_DW,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_w_enable,
    output logic [DW-1:0]            data_to_fifo,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_overlength
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BEATS + 1);

    arb_state_t    r_state, r_state_next;
    logic [GW-1:0] r_rr_ptr, r_rr_ptr_next;
    logic [GW-1:0] r_grant_id, r_grant_id_next;
    logic          r_busy, r_busy_next;
    logic [CW-1:0] r_beat_cnt, r_beat_cnt_next;
    logic          r_err, r_err_next;

    logic [GW-1:0] w_pick_idx;
    logic          w_pick_any;
    logic [DW-1:0] w_slices [N_REQ];
    logic          w_locked;
    logic          w_xfer;
    logic          w_cap;
    logic          w_release;
    logic          w_forced;

    rr_picker #(
        .N (N_REQ)
    ) u_picker (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Gating with rst keeps every write-side output quiet during reset.
    assign w_locked  = (r_state == LOCK) && !rst;
    assign w_xfer    = w_locked && req_valid[r_grant_id] && !fifo_full;
    assign w_cap     = (r_beat_cnt == CW'(MAX_BEATS - 1));
    assign w_release = w_xfer && (req_last[r_grant_id] || w_cap);
    assign w_forced  = w_xfer && !req_last[r_grant_id] && w_cap;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_slices[gi]  = req_data[gi*DW +: DW];
            assign req_ready[gi] = w_locked && !fifo_full && (r_grant_id == GW'(gi));
        end
    endgenerate

    assign fifo_w_enable  = w_xfer;
    assign data_to_fifo   = w_xfer ? w_slices[r_grant_id] : '0;
    assign grant_id       = r_grant_id;
    assign busy           = r_busy;
    assign err_overlength = r_err;

    always_comb begin
        r_state_next    = r_state;
        r_rr_ptr_next   = r_rr_ptr;
        r_grant_id_next = r_grant_id;
        r_busy_next     = r_busy;
        r_beat_cnt_next = r_beat_cnt;
        r_err_next      = w_forced;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    r_state_next    = LOCK;
                    r_grant_id_next = w_pick_idx;
                    r_busy_next     = 1'b1;
                    r_beat_cnt_next = '0;
                end
            end
            LOCK: begin
                if (w_xfer) begin
                    r_beat_cnt_next = r_beat_cnt + CW'(1);
                end
                // A forced release rotates priority exactly like a normal last beat.
                if (w_release) begin
                    r_state_next  = IDLE;
                    r_rr_ptr_next = GW'(wrap_inc(int'(r_grant_id), N_REQ));
                    r_busy_next   = 1'b0;
                end
            end
            default: begin
                r_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= r_state_next;
            r_rr_ptr   <= r_rr_ptr_next;
            r_grant_id <= r_grant_id_next;
            r_busy     <= r_busy_next;
            r_beat_cnt <= r_beat_cnt_next;
            r_err      <= r_err_next;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, round-robin, atomicity,
// back-pressure, overlength release and mid-packet reset.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 140;

    logic            clk_in = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            fifo_full = 1'b0;
    logic            fifo_w_enable;
    logic [DW-1:0]   data_to_fifo;
    logic [1:0]      grant_id;
    logic            busy;
    logic            err_overlength;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [DW-1:0] wq[$];
    int            wc[$];

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DW        (DW),
        .MAX_BEATS (16)
    ) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .fifo_full      (fifo_full),
        .fifo_w_enable  (fifo_w_enable),
        .data_to_fifo   (data_to_fifo),
        .grant_id       (grant_id),
        .busy           (busy),
        .err_overlength (err_overlength)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (fifo_w_enable) begin
            wq.push_back(data_to_fifo);
            wc.push_back(cyc);
            $display("write cyc=%0d grant=%0d data=%0h", cyc, grant_id, data_to_fifo);
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_data(input int i, input int v);
        req_data[i*DW +: DW] = DW'(v);
    endtask

    task automatic do_reset();
        tick();
        rst       = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        wq.delete();
        wc.delete();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int i = 0; i < N; i++) set_data(i, 'hA0 + i);
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            total++;
            if (fifo_w_enable !== 1'b0) begin bad++; $display("FAIL reset_wen c%0d: got %b want 0", c, fifo_w_enable); end
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy c%0d: got %b want 0", c, busy); end
            total++;
            if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant c%0d: got %0d want 0", c, grant_id); end
        end
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || fifo_w_enable !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b wen=%b want 0 0", busy, fifo_w_enable); end
        tick();
        #1;
        total++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin bad++; $display("FAIL reset_first_grant: busy=%b grant=%0d want 1 0", busy, grant_id); end
        total++;
        if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_ready: got %b want 0001", req_ready); end
        do_reset();
    endtask

    task automatic test_round_robin();
        int exp_d[8] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA0, 'hA1, 'hA2, 'hA3};
        tick();
        req_valid = 4'hF;
        req_last  = 4'hF;
        for (int i = 0; i < N; i++) set_data(i, 'hA0 + i);
        for (int c = 1; c < 16; c++) tick();
        tick();
        req_valid = '0;
        tick();
        total++;
        if (wq.size() != 8) begin bad++; $display("FAIL rr_count: got %0d want 8", wq.size()); end
        for (int i = 0; i < 8 && i < wq.size(); i++) begin
            total++;
            if (wq[i] !== DW'(exp_d[i])) begin bad++; $display("FAIL rr_data%0d: got %0h want %0h", i, wq[i], exp_d[i]); end
        end
        for (int i = 1; i < 8 && i < wc.size(); i++) begin
            total++;
            if (wc[i] - wc[i-1] != 2) begin bad++; $display("FAIL rr_spacing%0d: got %0d want 2", i, wc[i] - wc[i-1]); end
        end
        do_reset();
    endtask

    task automatic test_atomicity();
        int exp_d[4] = '{'h11, 'h12, 'h13, 'h22};
        tick();                                   // c0: req1 seen in IDLE
        req_valid = 4'b0010; req_last = 4'b0000; set_data(1, 'h11);
        tick();                                   // c1: beat 1, req2 arrives
        req_valid = 4'b0110; req_last = 4'b0100; set_data(2, 'h22);
        #1;
        total++;
        if (req_ready !== 4'b0010) begin bad++; $display("FAIL atom_ready_c1: got %b want 0010", req_ready); end
        tick();                                   // c2: beat 2
        set_data(1, 'h12);
        #1;
        total++;
        if (req_ready[2] !== 1'b0) begin bad++; $display("FAIL atom_ready2_c2: got %b want 0", req_ready[2]); end
        tick();                                   // c3: last beat
        set_data(1, 'h13); req_last = 4'b0110;
        #1;
        total++;
        if (req_ready[2] !== 1'b0) begin bad++; $display("FAIL atom_ready2_c3: got %b want 0", req_ready[2]); end
        tick();                                   // c4: IDLE picks req2
        req_valid = 4'b0100;
        #1;
        total++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL atom_idle: ready=%b busy=%b want 0000 0", req_ready, busy); end
        tick();                                   // c5: req2 beat
        #1;
        total++;
        if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin bad++; $display("FAIL atom_req2: ready=%b grant=%0d want 0100 2", req_ready, grant_id); end
        tick();
        req_valid = '0;
        tick();
        total++;
        if (wq.size() != 4) begin bad++; $display("FAIL atom_count: got %0d want 4", wq.size()); end
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            total++;
            if (wq[i] !== DW'(exp_d[i])) begin bad++; $display("FAIL atom_data%0d: got %0h want %0h", i, wq[i], exp_d[i]); end
        end
        do_reset();
    endtask

    task automatic test_backpressure();
        int exp_d[3] = '{'h01, 'h02, 'h03};
        tick();                                   // c0: IDLE
        req_valid = 4'b0001; req_last = 4'b0000; set_data(0, 'h01);
        tick();                                   // c1: beat 1
        tick();                                   // c2..c6: full
        set_data(0, 'h02); fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            #1;
            total++;
            if (fifo_w_enable !== 1'b0 || req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_stall%0d: wen=%b ready0=%b want 0 0", c, fifo_w_enable, req_ready[0]); end
        end
        tick();                                   // c7: beat 2 resumes
        fifo_full = 1'b0;
        #1;
        total++;
        if (fifo_w_enable !== 1'b1 || data_to_fifo !== DW'('h02)) begin bad++; $display("FAIL bp_resume: wen=%b data=%0h want 1 2", fifo_w_enable, data_to_fifo); end
        tick();                                   // c8: beat 3
        set_data(0, 'h03); req_last = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        total++;
        if (wq.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", wq.size()); end
        for (int i = 0; i < 3 && i < wq.size(); i++) begin
            total++;
            if (wq[i] !== DW'(exp_d[i])) begin bad++; $display("FAIL bp_data%0d: got %0h want %0h", i, wq[i], exp_d[i]); end
        end
        do_reset();
    endtask

    task automatic test_overlength();
        int beat = 1;
        int err_cnt = 0;
        int err_at = -1;
        int wr_at17 = -1;
        logic busy17 = 1'b1;
        logic [1:0] grant18 = 2'd0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (beat > 20) begin
                req_valid = '0;
                req_last  = '0;
            end else begin
                req_valid = 4'b1000;
                req_last  = (beat == 20) ? 4'b1000 : 4'b0000;
                set_data(3, 'h300 + beat);
            end
            #1;
            if (err_overlength === 1'b1) begin err_cnt++; err_at = c; end
            if (c == 17) begin busy17 = busy; wr_at17 = wq.size(); end
            if (c == 18) grant18 = grant_id;
            if (req_ready[3] === 1'b1 && req_valid[3]) beat++;
        end
        total++;
        if (err_cnt != 1) begin bad++; $display("FAIL ovl_err_count: got %0d want 1", err_cnt); end
        total++;
        if (err_at != 17) begin bad++; $display("FAIL ovl_err_cycle: got %0d want 17", err_at); end
        total++;
        if (busy17 !== 1'b0) begin bad++; $display("FAIL ovl_release: busy=%b want 0", busy17); end
        total++;
        if (wr_at17 != 16) begin bad++; $display("FAIL ovl_beats_before_release: got %0d want 16", wr_at17); end
        total++;
        if (grant18 !== 2'd3) begin bad++; $display("FAIL ovl_regrant: got %0d want 3", grant18); end
        total++;
        if (wq.size() != 20) begin bad++; $display("FAIL ovl_count: got %0d want 20", wq.size()); end
        for (int i = 0; i < 20 && i < wq.size(); i++) begin
            total++;
            if (wq[i] !== DW'('h301 + i)) begin bad++; $display("FAIL ovl_data%0d: got %0h want %0h", i, wq[i], 'h301 + i); end
        end
        do_reset();
    endtask

    task automatic test_mid_reset();
        tick();                                   // c0: req1 one-beat packet
        req_valid = 4'b0010; req_last = 4'b0010; set_data(1, 'h31);
        tick();                                   // c1: write 0x31
        req_valid = 4'b0110; set_data(2, 'h41);
        tick();                                   // c2: IDLE picks req2
        req_valid = 4'b0100;
        tick();                                   // c3: beat 1
        tick();                                   // c4: beat 2
        set_data(2, 'h42);
        tick();                                   // c5: reset mid-packet
        set_data(2, 'h43); rst = 1'b1;
        #1;
        total++;
        if (fifo_w_enable !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL mrst_quiet: wen=%b ready=%b want 0 0000", fifo_w_enable, req_ready); end
        tick();                                   // c6: back in IDLE
        rst = 1'b0; req_valid = 4'b0101; req_last = 4'b0101; set_data(0, 'h51);
        #1;
        total++;
        if (busy !== 1'b0 || fifo_w_enable !== 1'b0) begin bad++; $display("FAIL mrst_idle: busy=%b wen=%b want 0 0", busy, fifo_w_enable); end
        total++;
        if (wq.size() != 3) begin bad++; $display("FAIL mrst_count: got %0d want 3", wq.size()); end
        else begin
            total++;
            if (wq[1] !== DW'('h41) || wq[2] !== DW'('h42)) begin bad++; $display("FAIL mrst_data: got %0h %0h want 41 42", wq[1], wq[2]); end
        end
        tick();                                   // c7: fresh grant from req0
        #1;
        total++;
        if (grant_id !== 2'd0 || busy !== 1'b1) begin bad++; $display("FAIL mrst_regrant: grant=%0d busy=%b want 0 1", grant_id, busy); end
        total++;
        if (data_to_fifo !== DW'('h51)) begin bad++; $display("FAIL mrst_data0: got %0h want 51", data_to_fifo); end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_atomicity();
        test_backpressure();
        test_overlength();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
